// File: rtl/threshold_engine.sv
// Frame thresholding engine: reads each pixel from RAM, applies the selected threshold rule and writes it back in place.
// Define THRESHOLD_ENGINE_AUTO_EN to compile in the mean-derived (auto) threshold pass.
module threshold_engine #(
    parameter int PIX_W     = 8,
    parameter int ADDR_W    = 20,
    parameter int HDR_SIZE  = 54,
    parameter int PIX_COUNT = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              gray_done,
    input  logic [1:0]        mode,
    input  logic [PIX_W-1:0]  thresh,
    input  logic              auto_en,
    input  logic [PIX_W-1:0]  RAM_Q,
    output logic              RAM_ren,
    output logic              RAM_wen,
    output logic [PIX_W-1:0]  RAM_D,
    output logic [ADDR_W-1:0] RAM_addr,
    output logic [PIX_W-1:0]  thr_used,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(HDR_SIZE);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(HDR_SIZE + PIX_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        FIN
`ifdef THRESHOLD_ENGINE_AUTO_EN
        , SUM
`endif
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [ADDR_W-1:0]  r_addr;
    logic [PIX_W-1:0]   r_thr;
    logic [1:0]         r_mode;
    logic               w_accept;
    logic               w_lastPix;
    logic               w_above;
    logic [PIX_W-1:0]   w_pixOut;

    assign w_accept  = (r_state == IDLE) && start && gray_done;
    assign w_lastPix = (r_addr == LAST_ADDR);

`ifdef THRESHOLD_ENGINE_AUTO_EN
    localparam int                LOG2     = $clog2(PIX_COUNT);
    localparam int                SUM_W    = PIX_W + LOG2;
    localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(HDR_SIZE + PIX_COUNT);

    logic [SUM_W-1:0] r_sum;
    logic [SUM_W-1:0] w_sumNext;
    logic             w_sumEnd;
    logic             w_sumHasData;

    // Read data lags the address by one cycle, so the first SUM cycle has nothing to add
    // and one extra cycle at the end captures the last pixel.
    assign w_sumNext    = r_sum + SUM_W'(RAM_Q);
    assign w_sumEnd     = (r_addr == END_ADDR);
    assign w_sumHasData = (r_addr != FIRST_ADDR);
`else
    logic w_unused;
    assign w_unused = auto_en;
`endif

    always_comb begin
        w_above  = (RAM_Q > r_thr);
        w_pixOut = '0;
        case (r_mode)
            2'b00:   w_pixOut = w_above ? '1 : '0;
            2'b01:   w_pixOut = w_above ? '0 : '1;
            2'b10:   w_pixOut = w_above ? r_thr : RAM_Q;
            default: w_pixOut = w_above ? RAM_Q : '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        RAM_ren     = 1'b0;
        RAM_wen     = 1'b0;
        RAM_D       = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef THRESHOLD_ENGINE_AUTO_EN
                    w_nextState = auto_en ? SUM : RD;
`else
                    w_nextState = RD;
`endif
                end
            end
`ifdef THRESHOLD_ENGINE_AUTO_EN
            SUM: begin
                busy    = 1'b1;
                RAM_ren = !w_sumEnd;
                if (w_sumEnd) begin
                    w_nextState = RD;
                end
            end
`endif
            RD: begin
                busy        = 1'b1;
                RAM_ren     = 1'b1;
                w_nextState = WR;
            end
            WR: begin
                busy        = 1'b1;
                RAM_wen     = 1'b1;
                RAM_D       = w_pixOut;
                w_nextState = w_lastPix ? FIN : RD;
            end
            FIN: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Mode and threshold are captured only on an accepted start so changes mid-frame cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= FIRST_ADDR;
            r_thr  <= '0;
            r_mode <= 2'b00;
`ifdef THRESHOLD_ENGINE_AUTO_EN
            r_sum  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr <= FIRST_ADDR;
                        r_thr  <= thresh;
                        r_mode <= mode;
`ifdef THRESHOLD_ENGINE_AUTO_EN
                        r_sum  <= '0;
`endif
                    end
                end
`ifdef THRESHOLD_ENGINE_AUTO_EN
                SUM: begin
                    if (w_sumHasData) begin
                        r_sum <= w_sumNext;
                    end
                    if (w_sumEnd) begin
                        r_thr  <= w_sumNext[LOG2 +: PIX_W];
                        r_addr <= FIRST_ADDR;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
`endif
                WR: begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign RAM_addr = r_addr;
    assign thr_used = r_thr;

endmodule

// File: tb/tb_threshold_engine.sv
// Self-checking bench for threshold_engine with a 4-pixel frame behind a simple one-cycle-latency RAM model.
// Covers the directed vectors, reset abort, dropped starts, and randomized frames checked against a rule-level model.
module tb_threshold_engine;

    localparam int PIX_W  = 8;
    localparam int ADDR_W = 20;
    localparam int HDR    = 54;
    localparam int NPIX   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              gray_done;
    logic [1:0]        mode;
    logic [PIX_W-1:0]  thresh;
    logic              auto_en;
    logic [PIX_W-1:0]  RAM_Q = '0;
    logic              RAM_ren;
    logic              RAM_wen;
    logic [PIX_W-1:0]  RAM_D;
    logic [ADDR_W-1:0] RAM_addr;
    logic [PIX_W-1:0]  thr_used;
    logic              busy;
    logic              done;

    threshold_engine #(
        .PIX_W    (PIX_W),
        .ADDR_W   (ADDR_W),
        .HDR_SIZE (HDR),
        .PIX_COUNT(NPIX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .gray_done(gray_done),
        .mode     (mode),
        .thresh   (thresh),
        .auto_en  (auto_en),
        .RAM_Q    (RAM_Q),
        .RAM_ren  (RAM_ren),
        .RAM_wen  (RAM_wen),
        .RAM_D    (RAM_D),
        .RAM_addr (RAM_addr),
        .thr_used (thr_used),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // RAM model: registered read data, write on the clock edge, plus a bulk preload path.
    logic [7:0] mem     [0:127];
    logic [7:0] preload [0:127];
    logic       doLoad = 1'b0;

    always @(posedge clk) begin
        if (doLoad) begin
            mem <= preload;
        end else begin
            if (RAM_ren) RAM_Q <= mem[RAM_addr[6:0]];
            if (RAM_wen) mem[RAM_addr[6:0]] <= RAM_D;
        end
    end

    int checks = 0;
    int failures = 0;
    int rdCount, wrTotal, busyCycles, doneCount, oobCount, conflictCount, doneNoWr;
    int wrPer [0:127];
    logic prevWen = 1'b0;

    always @(negedge clk) begin
        if (RAM_ren && RAM_wen) conflictCount++;
        if ((RAM_ren || RAM_wen) && (RAM_addr < HDR || RAM_addr > HDR + NPIX - 1)) oobCount++;
        if (RAM_ren) rdCount++;
        if (RAM_wen) begin
            wrTotal++;
            wrPer[RAM_addr[6:0]]++;
        end
        if (busy) busyCycles++;
        if (done) begin
            doneCount++;
            if (!prevWen) doneNoWr++;
        end
        prevWen = RAM_wen;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] refPix(input logic [1:0] m, input logic [7:0] p, input logic [7:0] t);
        case (m)
            2'b00:   return (p > t) ? 8'hFF : 8'h00;
            2'b01:   return (p > t) ? 8'h00 : 8'hFF;
            2'b10:   return (p > t) ? t : p;
            default: return (p > t) ? p : 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    task automatic clearCounters();
        rdCount = 0; wrTotal = 0; busyCycles = 0; doneCount = 0;
        oobCount = 0; conflictCount = 0; doneNoWr = 0;
        for (int i = 0; i < 128; i++) wrPer[i] = 0;
    endtask

    task automatic loadMem(input logic [31:0] pixWord);
        @(negedge clk); #1;
        for (int i = 0; i < 128; i++) preload[i] = 8'h00;
        for (int i = 0; i < NPIX; i++) preload[HDR + i] = pixWord[8*i +: 8];
        preload[HDR - 1]    = 8'hA5;
        preload[HDR + NPIX] = 8'h5A;
        doLoad = 1'b1;
        @(negedge clk); #1;
        doLoad = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] t, input logic a, input logic disturb);
        int n;
        @(negedge clk); #1;
        clearCounters();
        mode = m; thresh = t; auto_en = a; gray_done = 1'b1; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        if (disturb) begin
            repeat (2) @(negedge clk);
            #1;
            start = 1'b1; mode = ~m; thresh = ~t; auto_en = ~a;
            @(negedge clk); #1;
            start = 1'b0;
        end
        n = 0;
        while (doneCount == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checkOutput("done_timeout", (doneCount != 0), 1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic runFrame(input string name, input logic [1:0] m, input logic [7:0] t, input logic a,
                            input logic [31:0] pixWord, input logic [31:0] expWord, input logic [7:0] expThr,
                            input int expBusy, input int expReads, input logic disturb);
        loadMem(pixWord);
        applyStimulus(m, t, a, disturb);
        for (int i = 0; i < NPIX; i++) begin
            checkOutput($sformatf("%s_pix%0d", name, i), mem[HDR + i], expWord[8*i +: 8]);
            checkOutput($sformatf("%s_wrcnt%0d", name, i), wrPer[HDR + i], 1);
        end
        checkOutput({name, "_donecnt"}, doneCount, 1);
        checkOutput({name, "_done_after_wr"}, doneNoWr, 0);
        checkOutput({name, "_oob"}, oobCount, 0);
        checkOutput({name, "_conflict"}, conflictCount, 0);
        checkOutput({name, "_thr_used"}, thr_used, expThr);
        checkOutput({name, "_busy_cycles"}, busyCycles, expBusy);
        checkOutput({name, "_reads"}, rdCount, expReads);
        checkOutput({name, "_final_addr"}, RAM_addr, HDR + NPIX);
        checkOutput({name, "_busy_idle"}, busy, 0);
        checkOutput({name, "_sentinel_lo"}, mem[HDR - 1], 8'hA5);
        checkOutput({name, "_sentinel_hi"}, mem[HDR + NPIX], 8'h5A);
    endtask

    typedef struct {
        string       name;
        logic [1:0]  m;
        logic [7:0]  t;
        logic [31:0] pix;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [31:0] basePix;
        int          n;

        basePix = pack4(8'd10, 8'd127, 8'd128, 8'd255);
        vecs[0] = '{"bin",    2'b00, 8'd127, basePix, pack4(8'd0, 8'd0, 8'd255, 8'd255)};
        vecs[1] = '{"inv",    2'b01, 8'd127, basePix, pack4(8'd255, 8'd255, 8'd0, 8'd0)};
        vecs[2] = '{"trunc",  2'b10, 8'd127, basePix, pack4(8'd10, 8'd127, 8'd127, 8'd127)};
        vecs[3] = '{"tozero", 2'b11, 8'd127, basePix, pack4(8'd0, 8'd0, 8'd128, 8'd255)};
        vecs[4] = '{"bin_t255", 2'b00, 8'd255, pack4(8'd255, 8'd0, 8'd254, 8'd1), pack4(8'd0, 8'd0, 8'd0, 8'd0)};
        vecs[5] = '{"inv_t0",   2'b01, 8'd0,   pack4(8'd0, 8'd1, 8'd255, 8'd0), pack4(8'd255, 8'd0, 8'd0, 8'd255)};

        rst = 1'b1; start = 1'b0; gray_done = 1'b0; mode = 2'b00; thresh = 8'd0; auto_en = 1'b0;
        clearCounters();
        repeat (2) @(negedge clk);
        checkOutput("rst_ren", RAM_ren, 0);
        checkOutput("rst_wen", RAM_wen, 0);
        checkOutput("rst_d", RAM_D, 0);
        checkOutput("rst_addr", RAM_addr, HDR);
        checkOutput("rst_thr", thr_used, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        #1 rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            runFrame(vecs[v].name, vecs[v].m, vecs[v].t, 1'b0, vecs[v].pix, vecs[v].exp,
                     vecs[v].t, 2 * NPIX, NPIX, 1'b0);
        end

        // A start without gray_done must be dropped, not remembered.
        loadMem(basePix);
        @(negedge clk); #1;
        clearCounters();
        gray_done = 1'b0; start = 1'b1; mode = 2'b00; thresh = 8'd127;
        @(negedge clk); #1;
        start = 1'b0; gray_done = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        checkOutput("drop_busy", busyCycles, 0);
        checkOutput("drop_access", rdCount + wrTotal, 0);
        checkOutput("drop_done", doneCount, 0);

        // Reset after the second write aborts the frame.
        loadMem(basePix);
        @(negedge clk); #1;
        clearCounters();
        mode = 2'b00; thresh = 8'd127; auto_en = 1'b0; gray_done = 1'b1; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        n = 0;
        while (wrTotal < 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        checkOutput("abort_wait", (wrTotal >= 2), 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("abort_ren", RAM_ren, 0);
        checkOutput("abort_wen", RAM_wen, 0);
        checkOutput("abort_d", RAM_D, 0);
        checkOutput("abort_addr", RAM_addr, HDR);
        checkOutput("abort_thr", thr_used, 0);
        checkOutput("abort_busy", busy, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checkOutput("abort_pix54", mem[HDR], 8'd0);
        checkOutput("abort_pix55", mem[HDR + 1], 8'd0);
        checkOutput("abort_pix56", mem[HDR + 2], 8'd128);
        checkOutput("abort_pix57", mem[HDR + 3], 8'd255);
        checkOutput("abort_wr56", wrPer[HDR + 2] + wrPer[HDR + 3], 0);
        checkOutput("abort_done", doneCount, 0);

`ifdef THRESHOLD_ENGINE_AUTO_EN
        runFrame("auto_mean", 2'b00, 8'd50, 1'b1, pack4(8'd0, 8'd100, 8'd200, 8'd100),
                 pack4(8'd0, 8'd0, 8'd255, 8'd0), 8'd100, 2 * NPIX + NPIX + 1, 2 * NPIX, 1'b0);
`else
        runFrame("auto_ignored", 2'b00, 8'd50, 1'b1, pack4(8'd0, 8'd100, 8'd200, 8'd100),
                 pack4(8'd0, 8'd255, 8'd255, 8'd255), 8'd50, 2 * NPIX, NPIX, 1'b0);
`endif

        // Randomized back-to-back frames, half of them disturbed mid-frame.
        for (int r = 0; r < 20; r++) begin
            logic [1:0]  m;
            logic [7:0]  t;
            logic        a;
            logic [7:0]  useThr;
            logic [31:0] pix;
            logic [31:0] expW;
            int          sum;
            int          eBusy;
            int          eReads;
            m = 2'($urandom_range(0, 3));
            t = 8'($urandom_range(0, 255));
            a = 1'($urandom_range(0, 1));
            sum = 0;
            for (int i = 0; i < NPIX; i++) begin
                pix[8*i +: 8] = ($urandom_range(0, 3) == 0) ? t : 8'($urandom_range(0, 255));
                sum += pix[8*i +: 8];
            end
`ifdef THRESHOLD_ENGINE_AUTO_EN
            useThr = a ? 8'(sum / NPIX) : t;
            eBusy  = a ? (3 * NPIX + 1) : 2 * NPIX;
            eReads = a ? 2 * NPIX : NPIX;
`else
            useThr = t;
            eBusy  = 2 * NPIX;
            eReads = NPIX;
`endif
            for (int i = 0; i < NPIX; i++) expW[8*i +: 8] = refPix(m, pix[8*i +: 8], useThr);
            runFrame($sformatf("rand%0d", r), m, t, a, pix, expW, useThr, eBusy, eReads, 1'(r % 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/threshold_engine.md
THRESHOLD_ENGINE -- requirements
Module: threshold_engine

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning pixel bit width.
REQ-002 SHALL have parameter ADDR_W, default 20, meaning RAM address width.
REQ-003 SHALL have parameter HDR_SIZE, default 54, meaning byte address of the first pixel.
REQ-004 SHALL have parameter PIX_COUNT, default 65536, meaning pixels per frame; SHALL be a power of two.
REQ-005 SHALL have port clk, input, 1, meaning the single clock (all logic on rising edge).
REQ-006 SHALL have port rst, input, 1, meaning asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1, meaning a one-cycle request to process a frame.
REQ-008 SHALL have port gray_done, input, 1, meaning upstream grayscale pass is complete.
REQ-009 SHALL have port mode, input, 2, meaning: 00 binary, 01 binary-inverted, 10 truncate, 11 to-zero.
REQ-010 SHALL have port thresh, input, PIX_W, meaning manual threshold T.
REQ-011 SHALL have port auto_en, input, 1, meaning: request a mean-derived threshold.
REQ-012 SHALL have port RAM_Q, input, PIX_W, meaning RAM read data, valid one cycle after RAM_ren.
REQ-013 SHALL have port RAM_ren, output, 1, meaning RAM read strobe.
REQ-014 SHALL have port RAM_wen, output, 1, meaning RAM write strobe.
REQ-015 SHALL have port RAM_D, output, PIX_W, meaning RAM write data.
REQ-016 SHALL have port RAM_addr, output, ADDR_W, meaning RAM address.
REQ-017 SHALL have port thr_used, output, PIX_W, meaning the threshold applied in the current or last frame.
REQ-018 SHALL have port busy, output, 1, meaning a frame is in progress.
REQ-019 SHALL have port done, output, 1, meaning a one-cycle pulse after the last pixel write.

Function
REQ-020 SHALL implement FSM states IDLE, SUM, RD, WR, FIN.
REQ-021 IDLE SHALL go to RD when start=1 and gray_done=1; a start without gray_done SHALL be dropped, not queued.
REQ-022 On an accepted start: SHALL latch mode and thresh into thr_used; SHALL set RAM_addr=HDR_SIZE; busy SHALL rise next cycle.
REQ-023 start while busy=1 SHALL be ignored; mode and thresh changes while busy=1 SHALL have no effect.
REQ-024 RD SHALL assert RAM_ren=1 and RAM_wen=0 at the current pixel address; next state SHALL be WR.
REQ-025 WR SHALL assert RAM_wen=1, RAM_ren=0 and RAM_D=f(RAM_Q), with p=RAM_Q, T=thr_used, MAX=all ones, compare strictly p>T:
  - binary: p>T ? MAX : 0
  - inverted: p>T ? 0 : MAX
  - truncate: p>T ? T : p
  - to-zero: p>T ? p : 0
REQ-026 After WR, RAM_addr SHALL increment by 1; the state SHALL go to RD, or to FIN if the written address was HDR_SIZE+PIX_COUNT-1.
REQ-027 Throughput SHALL be 2 cycles per pixel; each pixel address SHALL be written exactly once; no address outside [HDR_SIZE, HDR_SIZE+PIX_COUNT-1] SHALL be accessed.
REQ-028 FIN SHALL pulse done=1 for exactly one cycle, drop busy, and return to IDLE; RAM_addr SHALL hold its final value (HDR_SIZE+PIX_COUNT).
REQ-029 RAM_ren and RAM_wen SHALL never be high in the same cycle; RAM_D SHALL be registered or stable for the whole WR cycle.

Reset
REQ-030 On rst=1, asynchronously: state=IDLE, RAM_ren=0, RAM_wen=0, RAM_D=0, RAM_addr=HDR_SIZE, thr_used=0, busy=0, done=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no further reads or writes and no done pulse.

Configuration
REQ-032 Macro THRESHOLD_ENGINE_AUTO_EN SHALL compile in auto-threshold mode.
REQ-033 With the macro and auto_en=1 at start: the engine SHALL enter SUM instead of RD.
  - SUM SHALL assert RAM_ren every cycle across all pixel addresses.
  - SUM SHALL accumulate RAM_Q into a PIX_W+log2(PIX_COUNT)-bit sum with no overflow.
  - SUM SHALL take PIX_COUNT+1 cycles.
  - thr_used SHALL then become sum>>log2(PIX_COUNT) (truncating mean).
  - RAM_addr SHALL reset to HDR_SIZE, then the RD/WR pass SHALL proceed.
REQ-034 Without the macro, the auto_en port SHALL exist but be ignored, the SUM state and accumulator SHALL be absent, and thr_used SHALL always equal the latched thresh.

Verification (PIX_COUNT=4, HDR_SIZE=54, PIX_W=8)
REQ-035 Pixels {10,127,128,255}, mode=00, T=127 -> addresses 54..57 written {0,0,255,255}; done one pulse 1 cycle after the last WR.
REQ-036 Same pixels, modes 01/10/11 -> {255,255,0,0} / {10,127,127,127} / {0,0,128,255}.
REQ-037 start with gray_done=0, then gray_done=1 with no new start -> no RAM access, busy stays 0.
REQ-038 rst pulsed after the second WR -> outputs reach reset values immediately; pixels 56 and 57 remain unmodified; no done pulse.
REQ-039 With the macro: pixels {0,100,200,100}, auto_en=1, mode=00 -> thr_used=100; written {0,0,255,0}.
REQ-040 start and thresh changed during busy -> ignored; a second start after done -> a full frame is processed again.
